// File: rtl/lagarto0_pkg.sv
// rtl/lagarto0_pkg.sv - shared front-end types and constants for lagarto0
package lagarto0_pkg;

    localparam int XLEN_C = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t FETCH_BOOT  = 2'd0;
    localparam fetch_state_t FETCH_RUN   = 2'd1;
    localparam fetch_state_t FETCH_DRAIN = 2'd2;

    typedef struct packed {
        logic [31:0]       inst;
        logic [XLEN_C-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and decode handshakes of the fetch stage
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_resp_valid_i;
    logic [31:0]     imem_resp_data_i;
    logic            inst_valid_o;
    logic            inst_ready_i;
    logic [31:0]     inst_o;
    logic [XLEN-1:0] inst_pc_o;
    logic [6:0]      opcode_o;

    modport master (
        output imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, inst_pc_o, opcode_o,
        input  imem_req_ready_i, imem_resp_valid_i, imem_resp_data_i, inst_ready_i
    );

    modport slave (
        input  imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, inst_pc_o, opcode_o,
        output imem_req_ready_i, imem_resp_valid_i, imem_resp_data_i, inst_ready_i
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order FIFO of fetched {inst, pc} entries with flush
module fetch_queue
    import lagarto0_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A push into a full queue is only legal when the head leaves in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_push  = push_i && (!full_o || pop_i);
        do_pop   = pop_i && !empty_o;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage: PC, imem requests, squash on redirect, decode queue
module fetch_unit
    import lagarto0_pkg::*;
#(
    parameter int              XLEN     = XLEN_C,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    fetch_unit_if.master    bus
);
    localparam int PW  = $clog2(QDEPTH);
    localparam int CW  = PW + 1;
    localparam int CRW = CW + 1;
    localparam logic [CRW-1:0] CREDITS = CRW'(QDEPTH);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   squash_q, squash_d;
    logic [CW-1:0]   out_after_resp;
    logic [XLEN-1:0] shadow_q [QDEPTH];
    logic [XLEN-1:0] shadow_d [QDEPTH];
    logic [PW-1:0]   sh_wr_q, sh_wr_d, sh_rd_q, sh_rd_d;

    logic            req_valid, req_fire, resp_fire, q_push, q_pop;
    logic [CW-1:0]   q_count;
    logic            q_full, q_empty;
    fetch_entry_t    q_head, q_push_entry;
    logic [31:0]     inst_w;

    // Outstanding requests plus queued entries never exceed the queue depth, so every
    // response that survives squashing has a slot waiting for it.
    always_comb begin
        req_valid    = (state_q != FETCH_BOOT) && !redirect_i &&
                       (({1'b0, outstanding_q} + {1'b0, q_count}) < CREDITS);
        req_fire     = req_valid && bus.imem_req_ready_i;
        resp_fire    = bus.imem_resp_valid_i && (outstanding_q != '0);
        q_push       = resp_fire && (squash_q == '0) && !redirect_i;
        q_pop        = !q_empty && bus.inst_ready_i && !redirect_i;
        q_push_entry = '{inst: bus.imem_resp_data_i, pc: shadow_q[sh_rd_q]};
    end

    // The PC shadow tracks every issued request, squashed or not, so it stays aligned
    // with the in-order response stream.
    always_comb begin
        out_after_resp = outstanding_q - CW'(resp_fire);
        outstanding_d  = out_after_resp + CW'(req_fire);
        shadow_d       = shadow_q;
        sh_wr_d        = sh_wr_q;
        sh_rd_d        = sh_rd_q;
        fetch_pc_d     = fetch_pc_q;
        squash_d       = squash_q;

        if (req_fire) begin
            shadow_d[sh_wr_q] = fetch_pc_q;
            sh_wr_d           = sh_wr_q + 1'b1;
        end
        if (resp_fire) begin
            sh_rd_d = sh_rd_q + 1'b1;
        end

        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            squash_d   = out_after_resp;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (resp_fire && (squash_q != '0)) begin
                squash_d = squash_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            state_d = (squash_d != '0) ? FETCH_DRAIN : FETCH_RUN;
        end else begin
            case (state_q)
                FETCH_BOOT:  state_d = FETCH_RUN;
                FETCH_DRAIN: state_d = (squash_d == '0) ? FETCH_RUN : FETCH_DRAIN;
                default:     state_d = state_q;
            endcase
        end
    end

    always_comb begin
        inst_w    = q_empty ? NOP_INST : q_head.inst;
        last_pc_d = q_empty ? last_pc_q : q_head.pc;
    end

    assign bus.imem_req_valid_o = req_valid;
    assign bus.imem_req_addr_o  = fetch_pc_q;
    assign bus.inst_valid_o     = !q_empty;
    assign bus.inst_o           = inst_w;
    assign bus.inst_pc_o        = q_empty ? last_pc_q : q_head.pc;
    assign bus.opcode_o         = inst_w[6:0];

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .push_i      (q_push),
        .push_data_i (q_push_entry),
        .pop_i       (q_pop),
        .flush_i     (redirect_i),
        .head_o      (q_head),
        .count_o     (q_count),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= FETCH_BOOT;
            fetch_pc_q    <= RESET_PC;
            last_pc_q     <= '0;
            outstanding_q <= '0;
            squash_q      <= '0;
            shadow_q      <= '{default: '0};
            sh_wr_q       <= '0;
            sh_rd_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            last_pc_q     <= last_pc_d;
            outstanding_q <= outstanding_d;
            squash_q      <= squash_d;
            shadow_q      <= shadow_d;
            sh_wr_q       <= sh_wr_d;
            sh_rd_q       <= sh_rd_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rstn_i) !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a queue-level model
module tb_fetch_unit;
    import lagarto0_pkg::*;

    localparam int          QD     = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RST_PC),
        .QDEPTH   (QD)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .bus           (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] pc; bit stale; } inf_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    ent_t        dq[$];
    inf_t        infl[$];
    mreq_t       mem_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] issue_log[$];
    logic [31:0] m_pc, m_last;
    bit          m_boot;
    bit          saw_valid;
    int          cyc;
    int          n_vec, n_err;
    int          p_ready, p_dec, p_redir, lat_lo, lat_hi;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        redirect_i = 1'b0;
        bus.imem_resp_valid_i = 1'b0;
        bus.imem_req_ready_i = 1'b0;
        bus.inst_ready_i = 1'b0;
        #1;
        chk("rst_req_valid", bus.imem_req_valid_o, 32'd0);
        chk("rst_req_addr", bus.imem_req_addr_o, RST_PC);
        chk("rst_inst_valid", bus.inst_valid_o, 32'd0);
        chk("rst_inst", bus.inst_o, 32'h0000_0013);
        chk("rst_inst_pc", bus.inst_pc_o, 32'd0);
        chk("rst_opcode", bus.opcode_o, 32'h13);
        mem_q.delete(); dq.delete(); infl.delete();
        m_pc = RST_PC; m_last = '0; m_boot = 0;
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
    endtask

    // One clock cycle: drive at posedge+1, compare at posedge+4, advance model and memory.
    task automatic cycle(input bit force_rd, input logic [31:0] force_pc);
        bit          rd, rv, e_rv, m_fire, dec;
        logic [31:0] rpc, rdata, e_inst, e_pc;
        inf_t        f;
        rd  = force_rd || ($urandom_range(0, 99) < p_redir);
        if (force_rd) rpc = force_pc;
        else case ($urandom_range(0, 3))
            0:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            1:       rpc = $urandom & 32'h3FF;
            default: rpc = $urandom;
        endcase
        dec = ($urandom_range(0, 99) < p_dec);
        redirect_i = rd;
        redirect_pc_i = rpc;
        bus.imem_req_ready_i = ($urandom_range(0, 99) < p_ready);
        bus.inst_ready_i = dec;
        rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        rdata = rv ? word_of(mem_q[0].addr) : $urandom;
        bus.imem_resp_valid_i = rv;
        bus.imem_resp_data_i = rdata;
        #3;
        e_rv = m_boot && !rd && ((infl.size() + dq.size()) < QD);
        if (dq.size() > 0) begin e_inst = dq[0].inst; e_pc = dq[0].pc; end
        else begin e_inst = 32'h0000_0013; e_pc = m_last; end
        chk("req_valid", bus.imem_req_valid_o, e_rv);
        chk("req_addr", bus.imem_req_addr_o, m_pc);
        chk("inst_valid", bus.inst_valid_o, dq.size() > 0);
        chk("inst", bus.inst_o, e_inst);
        chk("inst_pc", bus.inst_pc_o, e_pc);
        chk("opcode", bus.opcode_o, e_inst[6:0]);
        saw_valid = bus.inst_valid_o;
        // environment: memory accepts and retires, decode consumes
        if (rv) void'(mem_q.pop_front());
        if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
            mem_q.push_back('{addr: bus.imem_req_addr_o, due: cyc + $urandom_range(lat_lo, lat_hi)});
            issue_log.push_back(bus.imem_req_addr_o);
        end
        if (bus.inst_valid_o && dec && !rd) pop_log.push_back(bus.inst_pc_o);
        // model
        m_fire = e_rv && bus.imem_req_ready_i;
        if (dq.size() > 0) m_last = dq[0].pc;
        if (dq.size() > 0 && dec && !rd) void'(dq.pop_front());
        if (rv && infl.size() > 0) begin
            f = infl.pop_front();
            if (!f.stale && !rd) dq.push_back('{inst: rdata, pc: f.pc});
        end
        if (rd) begin
            dq.delete();
            foreach (infl[i]) infl[i].stale = 1;
            m_pc = rpc & 32'hFFFF_FFFC;
        end else if (m_fire) begin
            infl.push_back('{pc: m_pc, stale: 0});
            m_pc = m_pc + 32'd4;
        end
        m_boot = 1;
        cyc++;
        @(posedge clk_i); #1;
        redirect_i = 1'b0;
        bus.imem_resp_valid_i = 1'b0;
    endtask

    initial begin
        int  first_v, stale_cnt;
        bit  found;
        logic [31:0] start;
        n_vec = 0; n_err = 0; cyc = 0;
        bus.imem_req_ready_i = 0; bus.imem_resp_valid_i = 0;
        bus.imem_resp_data_i = 0; bus.inst_ready_i = 0;
        p_ready = 100; p_dec = 100; p_redir = 0; lat_lo = 1; lat_hi = 1;
        @(posedge clk_i); #1;
        do_reset();

        // streaming from reset, 1-cycle memory
        first_v = -1; pop_log.delete();
        for (int i = 0; i < 12; i++) begin
            cycle(0, '0);
            if (saw_valid && first_v < 0) first_v = i;
        end
        chk("first_valid_cycle", first_v, 32'd3);
        chk("stream_n", pop_log.size() >= 3, 32'd1);
        if (pop_log.size() >= 3) begin
            chk("stream_pc0", pop_log[0], 32'h0);
            chk("stream_pc1", pop_log[1], 32'h4);
            chk("stream_pc2", pop_log[2], 32'h8);
        end

        // decode stall fills the queue and stops requests
        p_dec = 0;
        repeat (10) cycle(0, '0);
        chk("stall_req_valid", bus.imem_req_valid_o, 32'd0);
        chk("stall_inst_valid", bus.inst_valid_o, 32'd1);
        chk("stall_depth", dq.size(), QD);
        start = dq[0].pc;
        p_dec = 100; pop_log.delete();
        repeat (8) cycle(0, '0);
        for (int k = 0; k < pop_log.size(); k++) chk("stall_contig", pop_log[k], start + 32'(4 * k));

        // redirect with two stale responses in flight
        lat_lo = 3; lat_hi = 3; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (infl.size() == 2) found = 1; else cycle(0, '0);
        end
        chk("drain_setup", found, 32'd1);
        cycle(1, 32'h100);
        pop_log.delete();
        repeat (15) cycle(0, '0);
        chk("drain_n", pop_log.size() > 0, 32'd1);
        if (pop_log.size() > 0) chk("drain_first_pc", pop_log[0], 32'h100);
        stale_cnt = 0;
        foreach (pop_log[k]) if (pop_log[k] < 32'h100) stale_cnt++;
        chk("drain_no_stale", stale_cnt, 32'd0);

        // misaligned target, then redirect colliding with a response and a pop
        cycle(1, 32'h102);
        chk("align_addr", bus.imem_req_addr_o, 32'h100);
        lat_lo = 1; lat_hi = 1; found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (dq.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc) found = 1;
            else cycle(0, '0);
        end
        chk("collide_setup", found, 32'd1);
        cycle(1, 32'h180);
        chk("collide_flush", bus.inst_valid_o, 32'd0);
        repeat (10) cycle(0, '0);

        // PC wrap at the top of the address space
        cycle(1, 32'hFFFF_FFF8);
        issue_log.delete();
        repeat (10) cycle(0, '0);
        chk("wrap_n", issue_log.size() >= 3, 32'd1);
        if (issue_log.size() >= 3) begin
            chk("wrap_a0", issue_log[0], 32'hFFFF_FFF8);
            chk("wrap_a1", issue_log[1], 32'hFFFF_FFFC);
            chk("wrap_a2", issue_log[2], 32'h0000_0000);
        end

        // reset in the middle of a drain
        lat_lo = 4; lat_hi = 4; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (infl.size() == 2) found = 1; else cycle(0, '0);
        end
        chk("rdrain_setup", found, 32'd1);
        cycle(1, 32'h200);
        do_reset();
        cycle(0, '0);
        chk("restart_valid", bus.imem_req_valid_o, 32'd1);
        chk("restart_addr", bus.imem_req_addr_o, RST_PC);

        // randomized traffic
        p_redir = 5;
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) begin
                p_ready = $urandom_range(30, 100);
                p_dec   = $urandom_range(20, 100);
                lat_lo  = 1;
                lat_hi  = $urandom_range(1, 5);
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle(0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder. It owns the PC and issues word requests to instruction memory.
- Responses are buffered in a small in-order queue. The queue presents instruction, PC and opcode to decode via a valid/ready handshake.
- Taken branches and jal from execute redirect the PC, flush the queue, and squash in-flight responses.

Parameters:
- XLEN, 32, PC and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QDEPTH, 2, instruction queue entries (power of 2, ≥2). This is also the cap on outstanding requests plus queued entries.

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- redirect_i  in  1  taken branch/jal from execute
- redirect_pc_i  in  XLEN  redirect target
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  XLEN  word address of request
- imem_resp_valid_i  in  1  response valid (in order, 1 per accepted request, latency ≥1)
- imem_resp_data_i  in  32  instruction word
- inst_valid_o  out  1  queue head valid to decode
- inst_ready_i  in  1  decode consumes head
- inst_o  out  32  head instruction
- inst_pc_o  out  XLEN  PC of head instruction
- opcode_o  out  7  inst_o[6:0], feeds decoder opcode_i

Behaviour:
- Reset (rstn_i=0, async): state=BOOT, fetch_pc=RESET_PC, queue empty, outstanding=0, squash=0.
  - Reset outputs: imem_req_valid_o=0, imem_req_addr_o=RESET_PC, inst_valid_o=0, inst_o=32'h0000_0013, inst_pc_o=0, opcode_o=7'b0010011.
- FSM BOOT -> RUN: one idle cycle after reset release, then RUN. DRAIN is entered on redirect while outstanding>0.
- Request issue:
  - imem_req_valid_o = (state!=BOOT) && !redirect_i && (outstanding + count < QDEPTH).
  - imem_req_addr_o = fetch_pc.
  - On accept (valid&&ready): fetch_pc += 4 (mod 2^XLEN, wraps to 0) and outstanding += 1.
  - Memory may see valid withdrawn without ready; there is no valid-stability rule.
- Response:
  - If squash>0: the word is discarded, squash -= 1, outstanding -= 1.
  - Otherwise: the word is pushed with its PC (tracked by an issue-order PC shadow queue) and outstanding -= 1.
  - The credit rule guarantees the queue never overflows; an overflow is an assertion failure.
- Decode handshake:
  - inst_valid_o = count>0. Head pops when inst_valid_o && inst_ready_i.
  - While empty: inst_o = NOP 32'h0000_0013, inst_pc_o holds its last value.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Push into an empty queue is visible the next cycle (1-cycle response-to-decode latency).
- Redirect (redirect_i=1):
  - fetch_pc <= {redirect_pc_i[XLEN-1:2],2'b00}.
  - Queue flushed; a pop in the same cycle is ignored.
  - squash <= outstanding after this cycle's response (a response arriving this cycle is dropped and counted).
  - No request issues in the redirect cycle.
  - Next state = DRAIN if squash_next>0, else RUN.
- DRAIN: requests to the new PC may issue. Responses are dropped until squash==0, then state goes to RUN. A redirect in DRAIN re-applies the redirect rules; squash is recomputed from current outstanding.
- Mid-operation reset: all state returns to reset values immediately, and in-flight responses are ignored after release.
  - The memory model must also be reset; otherwise it is a bench error.

Decomposition:
- lagarto0_pkg gains:
  - XLEN_C
  - NOP_INST = 32'h0000_0013
  - OPC_* opcode constants shared with the decoder
  - fetch_state_t enum {BOOT, RUN, DRAIN}
  - fetch_entry_t struct {inst, pc}
- Sub-module fetch_queue: parameterised sync FIFO of fetch_entry_t with push/pop/flush, count, full/empty.
- fetch_unit holds the FSM, the PC, outstanding/squash counters and the PC shadow queue.

Test Plan:
- Reset release, imem_req_ready_i=1, 1-cycle memory, inst_ready_i=1 -> requests 0x0,0x4,0x8,…; decode sees inst_pc_o 0x0,0x4,0x8 in order, with the first inst_valid_o 3 cycles after release.
- Stall decode (inst_ready_i=0) for 10 cycles -> exactly QDEPTH entries held, imem_req_valid_o=0, no loss. On release, PCs continue contiguously.
- 3-cycle memory latency, redirect to 0x100 with 2 outstanding -> both stale responses dropped, next delivered inst_pc_o=0x100, no instruction at 0x8/0xC reaches decode.
- Redirect to 0x102 -> fetch address 0x100; redirect in the same cycle as a response and a pop -> queue empty next cycle, squash counted correctly.
- fetch_pc=32'hFFFF_FFFC accepted -> next request address 0x0000_0000.
- Assert rstn_i low mid-DRAIN for 1 cycle -> outputs return to reset values asynchronously; fetch restarts at RESET_PC after the BOOT cycle.
